fsm_quicksort_bank_sched: RTL and testbench

Scheduler that sequences the BANK_N sort banks through IDLE -> LOADING -> READY -> SORTING -> SORTED -> UNLOADING -> IDLE. It grants banks to the enqueue FSM, dispatches loaded banks to the single quicksort engine, and hands sorted banks to the dequeue FSM. Banks are visited in strict round-robin order, so output vectors leave in input order. It is the sole owner of per-bank status, count and error state.

---
 rtl/fsm_quicksort_bank_sched.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_fsm_quicksort_bank_sched.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_quicksort_bank_sched.sv
// ---------------------------------------------------------------------------
// fsm_quicksort_bank_sched
//
// Sequences BANK_N sort banks through
//   IDLE -> LOADING -> READY -> SORTING -> SORTED -> UNLOADING -> IDLE.
// Banks are handed out strictly round-robin by three pointers (write, sort,
// read), so vectors leave in the order they arrived. This block is the sole
// owner of per-bank status, entry count and error flag.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   enq_req_i / enq_gnt_o    enqueue FSM bank request / one-cycle grant
//   enq_bank_o               granted bank, held until the next grant
//   enq_done_i, enq_n_i,     load complete pulse with loaded count and
//   enq_err_i                overflow flag
//   sort_start_o, sort_bank_o, sort_n_o   sort engine dispatch
//   sort_done_i, sort_err_i  sort engine completion and error
//   deq_start_o, deq_bank_o, deq_n_o, deq_err_o   dequeue FSM dispatch
//   deq_done_i               unload complete pulse
//   bank_status_o            3 bits per bank, bank 0 in the LSBs
//   proto_err_o              sticky: a done pulse arrived with nothing active
//   busy_o                   any bank not IDLE
// ---------------------------------------------------------------------------
module fsm_quicksort_bank_sched #(
  parameter  int BANK_N = 2,
  parameter  int N      = 16,
  localparam int BW     = (BANK_N > 1) ? $clog2(BANK_N) : 1,
  localparam int NW     = $clog2(N) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enq_req_i,
  output logic                  enq_gnt_o,
  output logic [BW-1:0]         enq_bank_o,
  input  logic                  enq_done_i,
  input  logic [NW-1:0]         enq_n_i,
  input  logic                  enq_err_i,
  output logic                  sort_start_o,
  output logic [BW-1:0]         sort_bank_o,
  output logic [NW-1:0]         sort_n_o,
  input  logic                  sort_done_i,
  input  logic                  sort_err_i,
  output logic                  deq_start_o,
  output logic [BW-1:0]         deq_bank_o,
  output logic [NW-1:0]         deq_n_o,
  output logic                  deq_err_o,
  input  logic                  deq_done_i,
  output logic [3*BANK_N-1:0]   bank_status_o,
  output logic                  proto_err_o,
  output logic                  busy_o
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_LOADING   = 3'd1;
  localparam logic [2:0] ST_READY     = 3'd2;
  localparam logic [2:0] ST_SORTING   = 3'd3;
  localparam logic [2:0] ST_SORTED    = 3'd4;
  localparam logic [2:0] ST_UNLOADING = 3'd5;

  // Per-bank state
  logic [BANK_N-1:0][2:0]    status_q, status_d;
  logic [BANK_N-1:0][NW-1:0] n_q, n_d;
  logic [BANK_N-1:0]         err_q, err_d;

  // Pointers and activity flags
  logic [BW-1:0] wr_ptr_q, wr_ptr_d;
  logic [BW-1:0] srt_ptr_q, srt_ptr_d;
  logic [BW-1:0] rd_ptr_q, rd_ptr_d;
  logic          load_act_q, load_act_d;
  logic          sort_act_q, sort_act_d;
  logic          deq_act_q, deq_act_d;
  logic          proto_err_q, proto_err_d;
  logic          busy_q, busy_d;

  // Registered outputs
  logic          enq_gnt_q, enq_gnt_d;
  logic [BW-1:0] enq_bank_q, enq_bank_d;
  logic          sort_start_q, sort_start_d;
  logic [BW-1:0] sort_bank_q, sort_bank_d;
  logic [NW-1:0] sort_n_q, sort_n_d;
  logic          deq_start_q, deq_start_d;
  logic [BW-1:0] deq_bank_q, deq_bank_d;
  logic [NW-1:0] deq_n_q, deq_n_d;
  logic          deq_err_q, deq_err_d;

  // Dispatch decisions, taken from registered state only. A pointer whose
  // bank is not in the expected state simply waits: no skipping, so FIFO
  // order of bank usage holds.
  logic grant_s, sort_go_s, sort_real_s, deq_go_s;

  assign grant_s     = enq_req_i && !load_act_q && (status_q[wr_ptr_q] == ST_IDLE);
  assign sort_go_s   = !sort_act_q && (status_q[srt_ptr_q] == ST_READY);
  // Banks with 0 or 1 entries are already sorted; they bypass the engine.
  assign sort_real_s = sort_go_s && (n_q[srt_ptr_q] >= NW'(2));
  assign deq_go_s    = !deq_act_q && (status_q[rd_ptr_q] == ST_SORTED);

  // State and output register with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_q     <= '0;
      n_q          <= '0;
      err_q        <= '0;
      wr_ptr_q     <= '0;
      srt_ptr_q    <= '0;
      rd_ptr_q     <= '0;
      load_act_q   <= 1'b0;
      sort_act_q   <= 1'b0;
      deq_act_q    <= 1'b0;
      proto_err_q  <= 1'b0;
      busy_q       <= 1'b0;
      enq_gnt_q    <= 1'b0;
      enq_bank_q   <= '0;
      sort_start_q <= 1'b0;
      sort_bank_q  <= '0;
      sort_n_q     <= '0;
      deq_start_q  <= 1'b0;
      deq_bank_q   <= '0;
      deq_n_q      <= '0;
      deq_err_q    <= 1'b0;
    end else begin
      status_q     <= status_d;
      n_q          <= n_d;
      err_q        <= err_d;
      wr_ptr_q     <= wr_ptr_d;
      srt_ptr_q    <= srt_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      load_act_q   <= load_act_d;
      sort_act_q   <= sort_act_d;
      deq_act_q    <= deq_act_d;
      proto_err_q  <= proto_err_d;
      busy_q       <= busy_d;
      enq_gnt_q    <= enq_gnt_d;
      enq_bank_q   <= enq_bank_d;
      sort_start_q <= sort_start_d;
      sort_bank_q  <= sort_bank_d;
      sort_n_q     <= sort_n_d;
      deq_start_q  <= deq_start_d;
      deq_bank_q   <= deq_bank_d;
      deq_n_q      <= deq_n_d;
      deq_err_q    <= deq_err_d;
    end
  end

  // Next-state logic. Every event below targets a bank in a distinct status,
  // so several events in one cycle never collide on the same bank.
  always_comb begin
    status_d    = status_q;
    n_d         = n_q;
    err_d       = err_q;
    wr_ptr_d    = wr_ptr_q;
    srt_ptr_d   = srt_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    load_act_d  = load_act_q;
    sort_act_d  = sort_act_q;
    deq_act_d   = deq_act_q;
    proto_err_d = proto_err_q;
    busy_d      = 1'b0;

    if (grant_s) begin
      status_d[wr_ptr_q] = ST_LOADING;
      load_act_d         = 1'b1;
      wr_ptr_d           = wr_ptr_q + BW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (enq_done_i) begin
      if (load_act_q) begin
        status_d[enq_bank_q] = ST_READY;
        load_act_d           = 1'b0;
        // Overlong loads are clamped and flagged rather than trusted.
        if (enq_n_i > NW'(N)) begin
          n_d[enq_bank_q]   = NW'(N);
          err_d[enq_bank_q] = 1'b1;
        end else begin
          n_d[enq_bank_q]   = enq_n_i;
          err_d[enq_bank_q] = enq_err_i;
        end
      end else begin
        proto_err_d = 1'b1;
      end
    end else begin
      proto_err_d = proto_err_d;
    end

    if (sort_go_s) begin
      if (sort_real_s) begin
        status_d[srt_ptr_q] = ST_SORTING;
        sort_act_d          = 1'b1;
      end else begin
        status_d[srt_ptr_q] = ST_SORTED;
      end
      srt_ptr_d = srt_ptr_q + BW'(1);
    end else begin
      srt_ptr_d = srt_ptr_q;
    end

    if (sort_done_i) begin
      if (sort_act_q) begin
        status_d[sort_bank_q] = ST_SORTED;
        err_d[sort_bank_q]    = err_q[sort_bank_q] | sort_err_i;
        sort_act_d            = 1'b0;
      end else begin
        proto_err_d = 1'b1;
      end
    end else begin
      proto_err_d = proto_err_d;
    end

    if (deq_go_s) begin
      status_d[rd_ptr_q] = ST_UNLOADING;
      deq_act_d          = 1'b1;
      rd_ptr_d           = rd_ptr_q + BW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    if (deq_done_i) begin
      if (deq_act_q) begin
        status_d[deq_bank_q] = ST_IDLE;
        n_d[deq_bank_q]      = '0;
        err_d[deq_bank_q]    = 1'b0;
        deq_act_d            = 1'b0;
      end else begin
        proto_err_d = 1'b1;
      end
    end else begin
      proto_err_d = proto_err_d;
    end

    // busy tracks the status being registered this cycle
    for (int i = 0; i < BANK_N; i++) begin
      busy_d = busy_d | (status_d[i] != ST_IDLE);
    end
  end

  // Output next values: pulses follow the dispatch decision, bank/count
  // fields hold their value until the next dispatch of the same kind.
  always_comb begin
    enq_gnt_d    = grant_s;
    sort_start_d = sort_real_s;
    deq_start_d  = deq_go_s;

    if (grant_s) begin
      enq_bank_d = wr_ptr_q;
    end else begin
      enq_bank_d = enq_bank_q;
    end

    if (sort_real_s) begin
      sort_bank_d = srt_ptr_q;
      sort_n_d    = n_q[srt_ptr_q];
    end else begin
      sort_bank_d = sort_bank_q;
      sort_n_d    = sort_n_q;
    end

    if (deq_go_s) begin
      deq_bank_d = rd_ptr_q;
      deq_n_d    = n_q[rd_ptr_q];
      deq_err_d  = err_q[rd_ptr_q];
    end else begin
      deq_bank_d = deq_bank_q;
      deq_n_d    = deq_n_q;
      deq_err_d  = deq_err_q;
    end
  end

  assign enq_gnt_o     = enq_gnt_q;
  assign enq_bank_o    = enq_bank_q;
  assign sort_start_o  = sort_start_q;
  assign sort_bank_o   = sort_bank_q;
  assign sort_n_o      = sort_n_q;
  assign deq_start_o   = deq_start_q;
  assign deq_bank_o    = deq_bank_q;
  assign deq_n_o       = deq_n_q;
  assign deq_err_o     = deq_err_q;
  assign bank_status_o = status_q;
  assign proto_err_o   = proto_err_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_fsm_quicksort_bank_sched.sv
// ---------------------------------------------------------------------------
// Testbench for fsm_quicksort_bank_sched: directed cycle-accurate sequences
// followed by a randomized phase where small agents play the enqueue, sort
// and dequeue FSMs and a queue-based model predicts dispatch order, counts
// and error flags.
// ---------------------------------------------------------------------------
module tb_fsm_quicksort_bank_sched;

  localparam int BANK_N = 2;
  localparam int N      = 16;
  localparam int BW     = 1;
  localparam int NW     = 5;
  localparam int NLOADS = 40;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              enq_req = 1'b0;
  logic              enq_gnt;
  logic [BW-1:0]     enq_bank;
  logic              enq_done = 1'b0;
  logic [NW-1:0]     enq_n = '0;
  logic              enq_err = 1'b0;
  logic              sort_start;
  logic [BW-1:0]     sort_bank;
  logic [NW-1:0]     sort_n;
  logic              sort_done = 1'b0;
  logic              sort_err = 1'b0;
  logic              deq_start;
  logic [BW-1:0]     deq_bank;
  logic [NW-1:0]     deq_n;
  logic              deq_err;
  logic              deq_done = 1'b0;
  logic [3*BANK_N-1:0] bank_status;
  logic              proto_err;
  logic              busy;

  fsm_quicksort_bank_sched #(.BANK_N(BANK_N), .N(N)) dut (
    .clk(clk), .rst(rst),
    .enq_req_i(enq_req), .enq_gnt_o(enq_gnt), .enq_bank_o(enq_bank),
    .enq_done_i(enq_done), .enq_n_i(enq_n), .enq_err_i(enq_err),
    .sort_start_o(sort_start), .sort_bank_o(sort_bank), .sort_n_o(sort_n),
    .sort_done_i(sort_done), .sort_err_i(sort_err),
    .deq_start_o(deq_start), .deq_bank_o(deq_bank), .deq_n_o(deq_n),
    .deq_err_o(deq_err), .deq_done_i(deq_done),
    .bank_status_o(bank_status), .proto_err_o(proto_err), .busy_o(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // All driving and sampling happens on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    enq_req = 1'b0; enq_done = 1'b0; sort_done = 1'b0; deq_done = 1'b0;
    enq_err = 1'b0; sort_err = 1'b0; enq_n = '0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  // Reference model for the randomized phase
  typedef struct { int bank; int n; bit err; } rec_t;
  rec_t sort_q[$];
  rec_t deq_q[$];
  bit   sort_err_m [BANK_N];
  bit   run_agents = 1'b0;

  // Sort engine agent: checks each dispatch against the next load that
  // actually needs sorting, then completes it after a random delay.
  task automatic sort_agent();
    rec_t r;
    bit   e;
    while (run_agents) begin
      tick();
      if (sort_start) begin
        if (sort_q.size() == 0) begin
          check("sort_unexpected", 32'd1, 32'd0);
        end else begin
          r = sort_q.pop_front();
          check("sort_bank", sort_bank, r.bank);
          check("sort_n", sort_n, r.n);
        end
        repeat ($urandom_range(0, 5)) tick();
        e = ($urandom_range(0, 5) == 0);
        sort_err_m[sort_bank] = sort_err_m[sort_bank] | e;
        sort_done = 1'b1; sort_err = e;
        tick();
        sort_done = 1'b0; sort_err = 1'b0;
      end
    end
  endtask

  // Dequeue agent: every load must come out in arrival order.
  task automatic deq_agent();
    rec_t r;
    while (run_agents) begin
      tick();
      if (deq_start) begin
        if (deq_q.size() == 0) begin
          check("deq_unexpected", 32'd1, 32'd0);
        end else begin
          r = deq_q.pop_front();
          check("deq_bank", deq_bank, r.bank);
          check("deq_n", deq_n, r.n);
          check("deq_err", deq_err, r.err | sort_err_m[r.bank]);
          sort_err_m[r.bank] = 1'b0;
        end
        repeat ($urandom_range(0, 5)) tick();
        deq_done = 1'b1;
        tick();
        deq_done = 1'b0;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    rec_t r;
    int   exp_wr;
    int   nraw;
    bit   eraw;
    bit   got;
    int   sel;

    // ---- reset values ----
    do_reset();
    check("rst_status", bank_status, 32'd0);
    check("rst_busy", busy, 32'd0);
    check("rst_gnt", enq_gnt, 32'd0);
    check("rst_proto", proto_err, 32'd0);
    check("rst_sort_start", sort_start, 32'd0);
    check("rst_deq_start", deq_start, 32'd0);

    // ---- single bank full flow ----
    enq_req = 1'b1;
    tick();
    check("gnt0", enq_gnt, 32'd1);
    check("gnt0_bank", enq_bank, 32'd0);
    check("gnt0_status", bank_status[2:0], 32'd1);
    check("gnt0_busy", busy, 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("no_second_gnt", enq_gnt, 32'd0);
    end
    enq_req = 1'b0;
    enq_done = 1'b1; enq_n = 5'd5;
    tick();
    enq_done = 1'b0;
    check("ready_status", bank_status, 32'h02);
    tick();
    check("sort_start", sort_start, 32'd1);
    check("sort_bank", sort_bank, 32'd0);
    check("sort_n", sort_n, 32'd5);
    check("sorting_status", bank_status, 32'h03);
    tick();
    check("sort_start_pulse", sort_start, 32'd0);
    sort_done = 1'b1;
    tick();
    sort_done = 1'b0;
    check("sorted_status", bank_status, 32'h04);
    tick();
    check("deq_start", deq_start, 32'd1);
    check("deq_bank", deq_bank, 32'd0);
    check("deq_n", deq_n, 32'd5);
    check("deq_err", deq_err, 32'd0);
    check("unloading_status", bank_status, 32'h05);
    deq_done = 1'b1;
    tick();
    deq_done = 1'b0;
    check("idle_status", bank_status, 32'd0);
    check("idle_busy", busy, 32'd0);

    // ---- ping-pong between the two banks ----
    do_reset();
    enq_req = 1'b1;
    tick();
    check("pp_gnt_a", enq_bank, 32'd0);
    enq_req = 1'b0; enq_done = 1'b1; enq_n = 5'd7;
    tick();
    enq_done = 1'b0;
    tick();
    check("pp_sort_a", sort_start, 32'd1);
    enq_req = 1'b1;
    tick();
    check("pp_gnt_b", enq_gnt, 32'd1);
    check("pp_gnt_b_bank", enq_bank, 32'd1);
    enq_req = 1'b0; enq_done = 1'b1; enq_n = 5'd3;
    tick();
    enq_done = 1'b0;
    tick();
    check("pp_sort_b_held", sort_start, 32'd0);
    check("pp_status_wait", bank_status, {26'd0, 3'd2, 3'd3});
    sort_done = 1'b1;
    tick();
    sort_done = 1'b0;
    check("pp_status_a_sorted", bank_status, {26'd0, 3'd2, 3'd4});
    tick();
    check("pp_sort_b", sort_start, 32'd1);
    check("pp_sort_b_bank", sort_bank, 32'd1);
    check("pp_sort_b_n", sort_n, 32'd3);
    check("pp_deq_a", deq_start, 32'd1);
    check("pp_deq_a_bank", deq_bank, 32'd0);
    check("pp_deq_a_n", deq_n, 32'd7);
    sort_done = 1'b1; deq_done = 1'b1;
    tick();
    sort_done = 1'b0; deq_done = 1'b0;
    check("pp_two_dones", bank_status, {26'd0, 3'd4, 3'd0});
    tick();
    check("pp_deq_b", deq_start, 32'd1);
    check("pp_deq_b_bank", deq_bank, 32'd1);
    check("pp_deq_b_n", deq_n, 32'd3);
    deq_done = 1'b1;
    tick();
    deq_done = 1'b0;
    check("pp_busy", busy, 32'd0);

    // ---- saturating load on bank 0 ----
    enq_req = 1'b1;
    tick();
    check("sat_gnt_bank", enq_bank, 32'd0);
    enq_req = 1'b0; enq_done = 1'b1; enq_n = 5'd20;
    tick();
    enq_done = 1'b0;
    tick();
    check("sat_sort_n", sort_n, 32'd16);
    sort_done = 1'b1;
    tick();
    sort_done = 1'b0;
    tick();
    check("sat_deq_n", deq_n, 32'd16);
    check("sat_deq_err", deq_err, 32'd1);
    deq_done = 1'b1;
    tick();
    deq_done = 1'b0;

    // ---- single entry with load error on bank 1: engine bypassed ----
    enq_req = 1'b1;
    tick();
    check("one_gnt_bank", enq_bank, 32'd1);
    enq_req = 1'b0; enq_done = 1'b1; enq_n = 5'd1; enq_err = 1'b1;
    tick();
    enq_done = 1'b0; enq_err = 1'b0;
    check("one_ready", bank_status, {26'd0, 3'd2, 3'd0});
    tick();
    check("one_no_sort", sort_start, 32'd0);
    check("one_sorted", bank_status, {26'd0, 3'd4, 3'd0});
    tick();
    check("one_deq_start", deq_start, 32'd1);
    check("one_deq_bank", deq_bank, 32'd1);
    check("one_deq_n", deq_n, 32'd1);
    check("one_deq_err", deq_err, 32'd1);
    deq_done = 1'b1;
    tick();
    deq_done = 1'b0;

    // ---- spurious done ----
    check("proto_clear", proto_err, 32'd0);
    sort_done = 1'b1;
    tick();
    sort_done = 1'b0;
    check("proto_set", proto_err, 32'd1);
    check("proto_status", bank_status, 32'd0);
    check("proto_busy", busy, 32'd0);

    // ---- asynchronous reset while sorting ----
    enq_req = 1'b1;
    tick();
    enq_req = 1'b0; enq_done = 1'b1; enq_n = 5'd4;
    tick();
    enq_done = 1'b0;
    tick();
    check("mid_sorting", bank_status, 32'h03);
    #1 rst = 1'b1;
    #1;
    check("async_status", bank_status, 32'd0);
    check("async_proto", proto_err, 32'd0);
    check("async_sort_n", sort_n, 32'd0);
    tick();
    rst = 1'b0;
    enq_req = 1'b1;
    tick();
    check("post_rst_gnt", enq_gnt, 32'd1);
    check("post_rst_bank", enq_bank, 32'd0);
    enq_req = 1'b0;

    // ---- randomized phase ----
    do_reset();
    for (int b = 0; b < BANK_N; b++) sort_err_m[b] = 1'b0;
    run_agents = 1'b1;
    exp_wr = 0;
    fork
      sort_agent();
      deq_agent();
    join_none
    for (int t = 0; t < NLOADS; t++) begin
      repeat ($urandom_range(0, 3)) tick();
      enq_req = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 300 && !got; k++) begin
        tick();
        got = enq_gnt;
      end
      enq_req = 1'b0;
      check("rnd_gnt_seen", got, 32'd1);
      if (!got) break;
      check("rnd_gnt_bank", enq_bank, exp_wr);
      exp_wr = (exp_wr + 1) % BANK_N;
      repeat ($urandom_range(0, 4)) tick();
      sel = $urandom_range(0, 9);
      if (sel == 0)      nraw = $urandom_range(17, 31);
      else if (sel == 1) nraw = $urandom_range(0, 1);
      else               nraw = $urandom_range(2, 16);
      eraw = ($urandom_range(0, 7) == 0);
      r.bank = enq_bank;
      r.n    = (nraw > N) ? N : nraw;
      r.err  = eraw | (nraw > N);
      if (r.n >= 2) sort_q.push_back(r);
      deq_q.push_back(r);
      enq_done = 1'b1; enq_n = NW'(nraw); enq_err = eraw;
      tick();
      enq_done = 1'b0; enq_err = 1'b0;
    end
    for (int k = 0; k < 1000; k++) begin
      if (deq_q.size() == 0 && !busy && !deq_done) break;
      tick();
    end
    check("rnd_drained", deq_q.size(), 32'd0);
    check("rnd_sort_drained", sort_q.size(), 32'd0);
    check("rnd_busy", busy, 32'd0);
    check("rnd_proto", proto_err, 32'd0);
    run_agents = 1'b0;
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
